mux_nto1_pipe: RTL and testbench

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_nto1_sel.sv | 26 ++
 rtl/mux_nto1_pipe.sv | 98 +++++++++
 tb/tb_mux_nto1_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared defaults and the lane-index width helper for the N-to-1 pipelined mux.
package mux_pkg;

    localparam int MUX_DEF_WIDTH  = 32;
    localparam int MUX_DEF_INPUTS = 6;

    // Selector width for n lanes, never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_sel.sv
// Combinational lane selector; any out-of-range index falls back to the last lane.
module mux_nto1_sel
    import mux_pkg::*;
#(
    parameter int N_INPUTS = MUX_DEF_INPUTS,
    parameter int WIDTH    = MUX_DEF_WIDTH,
    localparam int SEL_W   = lane_idx_w(N_INPUTS)
) (
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [N_INPUTS*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_out_of_range
);

    always_comb begin
        o_data = i_data[(N_INPUTS-1)*WIDTH +: WIDTH];
        for (int i = 0; i < N_INPUTS-1; i++) begin
            if (int'(i_sel) == i) begin
                o_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_out_of_range = (int'(i_sel) >= N_INPUTS);

endmodule

// File: rtl/mux_nto1_pipe.sv
// N-to-1 mux feeding a 2-entry skid FIFO with valid/ready handshakes on both sides
// and a sticky out-of-range selector flag.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int N_INPUTS = MUX_DEF_INPUTS,
    parameter int WIDTH    = MUX_DEF_WIDTH,
    localparam int SEL_W   = lane_idx_w(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          selector,
    input  logic [N_INPUTS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    input  logic                      clr_err
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_oor;
    logic             w_accept;
    logic             w_pop;

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_sel_err;

    mux_nto1_sel #(
        .N_INPUTS (N_INPUTS),
        .WIDTH    (WIDTH)
    ) u_sel (
        .i_sel          (selector),
        .i_data         (data_in),
        .o_data         (w_sel_data),
        .o_out_of_range (w_oor)
    );

    // Handshake flags come from registered occupancy only, so no input-to-output path.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign data_out  = r_head;
    assign sel_err   = r_sel_err;

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            unique case (r_count)
                2'd0: begin
                    if (w_accept) begin
                        r_head  <= w_sel_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_sel_data;
                    end else if (w_accept) begin
                        r_tail  <= w_sel_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    // Full: only a pop is possible, promoting the second entry.
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    // Setting on an out-of-range accept takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_oor) begin
            r_sel_err <= 1'b1;
        end else if (clr_err) begin
            r_sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: accepts push expected words, a negedge monitor pops and compares.
module tb_mux_nto1_pipe;

    localparam int N  = 6;
    localparam int W  = 32;
    localparam int SW = 3;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [SW-1:0]    selector;
    logic [N*W-1:0]   data_in;
    logic [W-1:0]     data_out;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;
    logic             clr_err;

    logic [W-1:0]     exp_word;
    logic [W-1:0]     sb_q[$];
    int               checks;
    int               failures;
    logic             prev_hold;
    logic [W-1:0]     prev_data;

    mux_nto1_pipe #(
        .N_INPUTS (N),
        .WIDTH    (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .selector  (selector),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] lane_val(input logic [SW-1:0] s);
        return (int'(s) >= N) ? 32'hA5 : (32'hA0 + 32'(s));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [SW-1:0] s);
        in_valid = 1'b1;
        selector = s;
        exp_word = lane_val(s);
    endtask

    // Monitor: occupancy model, stability under backpressure, pop/compare, then record accepts.
    always @(negedge clk) begin
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            check("in_ready_vs_model", 32'(in_ready), 32'(sb_q.size() != 2));
            check("out_valid_vs_model", 32'(out_valid), 32'(sb_q.size() != 0));
            if (prev_hold && out_valid)
                check("hold_stable", data_out, prev_data);
            prev_hold = out_valid && !out_ready;
            prev_data = data_out;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_unexpected", data_out, 32'hDEAD_BEEF);
                end else begin
                    check("pop_data", data_out, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(exp_word);
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int i = 0; i < N; i++)
            data_in[i*W +: W] = 32'hA0 + 32'(i);
        reset     = 1'b0;
        in_valid  = 1'b0;
        selector  = '0;
        exp_word  = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data_out", data_out, 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single beat, 1-cycle latency.
        out_ready = 1'b1;
        offer(3'd3);
        tick();
        in_valid = 1'b0;
        check("lat1_data", data_out, 32'hA3);
        check("lat1_valid", 32'(out_valid), 32'd1);
        tick();
        check("lat1_drained", 32'(out_valid), 32'd0);

        // Backpressure fills the skid buffer; third beat waits.
        out_ready = 1'b0;
        offer(3'd1);
        tick();
        offer(3'd2);
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        offer(3'd4);
        tick();
        check("full_head_held", data_out, 32'hA1);
        check("full_in_ready2", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("after_pop_head", data_out, 32'hA2);
        tick();
        in_valid = 1'b0;
        check("reaccept_head", data_out, 32'hA4);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Out-of-range selector, clear, and set-wins-over-clear.
        offer(3'd7);
        tick();
        in_valid = 1'b0;
        check("oor_data", data_out, 32'hA5);
        check("oor_err_set", 32'(sel_err), 32'd1);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("err_cleared", 32'(sel_err), 32'd0);
        offer(3'd6);
        clr_err = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_err  = 1'b0;
        check("set_wins", 32'(sel_err), 32'd1);
        check("sel6_data", data_out, 32'hA5);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Full-rate stream of 100 beats.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            offer(3'($urandom_range(0, 5)));
            tick();
            check("stream_no_gap", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_err_clear", 32'(sel_err), 32'd0);

        // Random backpressure and traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) offer(3'($urandom_range(0, 7)));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("bp_queue_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while full discards both words.
        out_ready = 1'b0;
        offer(3'd1);
        tick();
        offer(3'd2);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_data_out", data_out, 32'd0);
        check("arst_sel_err", 32'(sel_err), 32'd0);
        sb_q.delete();
        reset     = 1'b1;
        out_ready = 1'b1;
        offer(3'd0);
        tick();
        in_valid = 1'b0;
        check("post_rst_first", data_out, 32'hA0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        tick();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        tick();
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
